// File: rtl/clock_pkg.sv
// Field widths and legal maxima for the time-of-day registers.
// The calendar and display stages reuse these.
package clock_pkg;
  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;

  function automatic logic time_valid(input logic [HOUR_W-1:0] h,
                                      input logic [MIN_W-1:0]  m,
                                      input logic [SEC_W-1:0]  s);
    return (h <= HOUR_MAX) && (m <= MIN_MAX) && (s <= SEC_MAX);
  endfunction
endpackage

// File: rtl/rise_sync_detect.sv
// Two-flop synchroniser plus rising-edge detector for an asynchronous level.
// No edge is reported until the synchronised input has been seen low after reset.
module rise_sync_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic tick
);
  logic       s1, s2, p, armed;
  logic [1:0] fill;

  // fill[1] marks that s2 holds a genuine input sample rather than its
  // reset zero; arming on the reset zero would let an already-high input
  // produce a false edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      p     <= 1'b0;
      armed <= 1'b0;
      fill  <= 2'b00;
    end else begin
      s1   <= din;
      s2   <= s1;
      p    <= s2;
      fill <= {fill[0], 1'b1};
      if (fill[1] && !s2) armed <= 1'b1;
    end
  end

  assign tick = s2 & ~p & armed;
endmodule

// File: rtl/time_keeper.sv
// Hours:minutes:seconds time-of-day counter driven by a synchronised 1 Hz wave,
// with a validated load port and a midnight day_tick for the calendar stage.
module time_keeper
  import clock_pkg::*;
#(
  parameter int RESET_HOUR = 0,
  parameter int RESET_MIN  = 0,
  parameter int RESET_SEC  = 0
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  input  logic              clk_1Hz,
  input  logic              set_en,
  input  logic [HOUR_W-1:0] set_hour,
  input  logic [MIN_W-1:0]  set_min,
  input  logic [SEC_W-1:0]  set_sec,
  output logic [HOUR_W-1:0] hour,
  output logic [MIN_W-1:0]  min,
  output logic [SEC_W-1:0]  sec,
  output logic              sec_tick,
  output logic              day_tick,
  output logic              set_err
);
  logic tick;

  rise_sync_detect u_sync (
    .clk   (clk_100MHz),
    .reset (reset),
    .din   (clk_1Hz),
    .tick  (tick)
  );

  // A set in the same cycle as a tick wins; the tick is dropped, not deferred.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      hour     <= HOUR_W'(RESET_HOUR);
      min      <= MIN_W'(RESET_MIN);
      sec      <= SEC_W'(RESET_SEC);
      sec_tick <= 1'b0;
      day_tick <= 1'b0;
      set_err  <= 1'b0;
    end else begin
      sec_tick <= 1'b0;
      day_tick <= 1'b0;
      set_err  <= 1'b0;
      if (set_en) begin
        if (time_valid(set_hour, set_min, set_sec)) begin
          hour <= set_hour;
          min  <= set_min;
          sec  <= set_sec;
        end else begin
          set_err <= 1'b1;
        end
      end else if (tick) begin
        sec_tick <= 1'b1;
        if (sec == SEC_MAX) begin
          sec <= '0;
          if (min == MIN_MAX) begin
            min <= '0;
            if (hour == HOUR_MAX) begin
              hour     <= '0;
              day_tick <= 1'b1;
            end else begin
              hour <= hour + 5'd1;
            end
          end else begin
            min <= min + 6'd1;
          end
        end else begin
          sec <= sec + 6'd1;
        end
      end
    end
  end
endmodule
